// File: rtl/servo_bank.sv
// servo_bank: multi-channel servo PWM generator.
// One shared prescaler (1 us tick) and one frame counter feed an array of
// per-channel slices; each slice holds a clamped target, a slew-limited
// applied width and a registered PWM output. Applied width and enable only
// change on the frame boundary, where the frame counter wraps to 0, so a
// pulse can never be cut short or stretched mid-frame.

module servo_bank_ch #(
  parameter int PW_W      = 11,
  parameter int US_W      = 15,
  parameter int PW_MIN_US = 1000,
  parameter int PW_MAX_US = 2000,
  parameter int CENTER_US = 1500,
  parameter int SLEW_US   = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bnd_i,
  input  logic            en_i,
  input  logic [US_W-1:0] us_i,
  input  logic [PW_W-1:0] tgt_pw_i,
  input  logic            tgt_vld_i,
  output logic            pwm_o,
  output logic [PW_W-1:0] cur_o,
  output logic            settled_o
);
  localparam int CMP_W = (US_W > PW_W) ? US_W : PW_W;
  localparam logic [PW_W-1:0] MIN_V    = PW_W'(PW_MIN_US);
  localparam logic [PW_W-1:0] MAX_V    = PW_W'(PW_MAX_US);
  localparam logic [PW_W-1:0] CENTER_V = PW_W'(CENTER_US);
  localparam logic [PW_W-1:0] SLEW_PW  = PW_W'(SLEW_US);
  localparam logic [PW_W:0]   SLEW_MAG = (PW_W+1)'(SLEW_US);

  logic [PW_W-1:0] tgt_q, tgt_d, cur_q, cur_d, tgt_clamp, cur_step;
  logic signed [PW_W:0] diff;
  logic [PW_W:0] mag;
  logic pwm_q, pwm_d;

  // Clamp on load so the stored target is always inside the legal range.
  always_comb begin
    tgt_clamp = tgt_pw_i;
    if (tgt_pw_i < MIN_V)      tgt_clamp = MIN_V;
    else if (tgt_pw_i > MAX_V) tgt_clamp = MAX_V;
    tgt_d = tgt_vld_i ? tgt_clamp : tgt_q;
  end

  // Slew step toward the target taken with the pre-load target value.
  always_comb begin
    diff = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
    mag  = diff[PW_W] ? $unsigned(-diff) : $unsigned(diff);
    if (SLEW_US == 0 || mag <= SLEW_MAG) cur_step = tgt_q;
    else if (diff[PW_W])                 cur_step = cur_q - SLEW_PW;
    else                                 cur_step = cur_q + SLEW_PW;
    cur_d = bnd_i ? cur_step : cur_q;
    pwm_d = en_i && (CMP_W'(us_i) < CMP_W'(cur_q));
  end

  // Channel state; async reset also drops the pin immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= CENTER_V;
      cur_q <= CENTER_V;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign cur_o     = cur_q;
  assign settled_o = (cur_q == tgt_q);
endmodule

module servo_bank #(
  parameter int NUM_CH       = 2,
  parameter int CLK_FREQ_MHZ = 50,
  parameter int PW_W         = 11,
  parameter int PERIOD_US    = 20000,
  parameter int PW_MIN_US    = 1000,
  parameter int PW_MAX_US    = 2000,
  parameter int CENTER_US    = 1500,
  parameter int SLEW_US      = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH*PW_W-1:0]   target_pw,
  input  logic [NUM_CH-1:0]        target_valid,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH*PW_W-1:0]   current_pw,
  output logic [NUM_CH-1:0]        settled,
  output logic                     frame_start
);
  localparam int PRE_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam int US_W  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [US_W-1:0]  us_q, us_d;
  logic tick, bnd, en_q, en_d, fs_q;

  // Shared timebase: 1 us tick and microsecond position within the frame.
  always_comb begin
    tick  = (pre_q == PRE_W'(CLK_FREQ_MHZ - 1));
    bnd   = tick && (us_q == US_W'(PERIOD_US - 1));
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    us_d  = us_q;
    if (tick) us_d = (us_q == US_W'(PERIOD_US - 1)) ? '0 : us_q + US_W'(1);
    en_d  = bnd ? enable : en_q;
  end

  // Timebase, frame-latched enable and frame_start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      us_q  <= '0;
      en_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      us_q  <= us_d;
      en_q  <= en_d;
      fs_q  <= bnd;
    end
  end

  assign frame_start = fs_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_bank_ch #(
      .PW_W(PW_W), .US_W(US_W), .PW_MIN_US(PW_MIN_US), .PW_MAX_US(PW_MAX_US),
      .CENTER_US(CENTER_US), .SLEW_US(SLEW_US)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .bnd_i    (bnd),
      .en_i     (en_q),
      .us_i     (us_q),
      .tgt_pw_i (target_pw[g*PW_W +: PW_W]),
      .tgt_vld_i(target_valid[g]),
      .pwm_o    (pwm_out[g]),
      .cur_o    (current_pw[g*PW_W +: PW_W]),
      .settled_o(settled[g])
    );
  end
endmodule

// File: tb/tb_servo_bank.sv
// Bench for servo_bank: two instances share the stimulus, one slew-limited
// (SLEW 8) and one jumping directly (SLEW 0). A frame-level model tracks the
// edge count since reset, targets and applied widths, and the outputs of
// both instances are compared to it every cycle.
module tb_servo_bank;
  localparam int NCH = 2, CLKF = 2, PW_W = 11, PER = 100;
  localparam int PMIN = 10, PMAX = 60, CEN = 30, SLEW = 8;
  localparam int FRAME = PER * CLKF;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [NCH*PW_W-1:0] target_pw = '0;
  logic [NCH-1:0] target_valid = '0;
  logic [NCH-1:0] pwm_a, pwm_b, set_a, set_b;
  logic [NCH*PW_W-1:0] cur_a, cur_b;
  logic fs_a, fs_b;

  int checks = 0, errors = 0;

  servo_bank #(.NUM_CH(NCH), .CLK_FREQ_MHZ(CLKF), .PW_W(PW_W), .PERIOD_US(PER),
    .PW_MIN_US(PMIN), .PW_MAX_US(PMAX), .CENTER_US(CEN), .SLEW_US(SLEW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .target_pw(target_pw),
    .target_valid(target_valid), .pwm_out(pwm_a), .current_pw(cur_a),
    .settled(set_a), .frame_start(fs_a));

  servo_bank #(.NUM_CH(NCH), .CLK_FREQ_MHZ(CLKF), .PW_W(PW_W), .PERIOD_US(PER),
    .PW_MIN_US(PMIN), .PW_MAX_US(PMAX), .CENTER_US(CEN), .SLEW_US(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .target_pw(target_pw),
    .target_valid(target_valid), .pwm_out(pwm_b), .current_pw(cur_b),
    .settled(set_b), .frame_start(fs_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int sl(input logic [NCH*PW_W-1:0] v, input int i);
    logic [NCH*PW_W-1:0] t;
    t = v >> (i * PW_W);
    return int'(t[PW_W-1:0]);
  endfunction

  // ---------------- behavioural model ----------------
  int n = 0;                 // clock edges since reset release
  int tgt [NCH];
  int ma  [NCH];             // applied width, slew-limited instance
  int mb  [NCH];             // applied width, direct instance
  bit men = 0;               // enable as latched at the latest boundary

  function automatic int clampv(input int v);
    return (v < PMIN) ? PMIN : (v > PMAX) ? PMAX : v;
  endfunction

  function automatic int stepv(input int c, input int t, input int s);
    int d;
    d = t - c;
    if (s == 0 || (d <= s && d >= -s)) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  // pulse is high on edges 1..2*cur after a boundary, only if enabled then
  function automatic int pwm_exp(input int c);
    int k;
    k = n % FRAME;
    return (men && n >= FRAME && k >= 1 && k <= c * CLKF) ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; men = 0;
        for (int i = 0; i < NCH; i++) begin tgt[i] = CEN; ma[i] = CEN; mb[i] = CEN; end
      end else begin
        n++;
        if (n % FRAME == 0) begin
          men = enable;
          for (int i = 0; i < NCH; i++) begin
            ma[i] = stepv(ma[i], tgt[i], SLEW);
            mb[i] = stepv(mb[i], tgt[i], 0);
          end
        end
        for (int i = 0; i < NCH; i++)
          if (target_valid[i]) tgt[i] = clampv(sl(target_pw, i));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("cur_a%0d n=%0d", i, n), sl(cur_a, i), ma[i]);
        chk($sformatf("cur_b%0d n=%0d", i, n), sl(cur_b, i), mb[i]);
        chk($sformatf("set_a%0d n=%0d", i, n), int'(set_a[i]), (ma[i] == tgt[i]) ? 1 : 0);
        chk($sformatf("set_b%0d n=%0d", i, n), int'(set_b[i]), (mb[i] == tgt[i]) ? 1 : 0);
        chk($sformatf("pwm_a%0d n=%0d", i, n), int'(pwm_a[i]), pwm_exp(ma[i]));
        chk($sformatf("pwm_b%0d n=%0d", i, n), int'(pwm_b[i]), pwm_exp(mb[i]));
      end
      chk($sformatf("fs_a n=%0d", n), int'(fs_a), (n >= FRAME && n % FRAME == 0) ? 1 : 0);
      chk($sformatf("fs_b n=%0d", n), int'(fs_b), (n >= FRAME && n % FRAME == 0) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_fs();
    int c = 0;
    do begin @(negedge clk); c++; end while (!fs_a && c < 2 * FRAME);
    chk("fs_wait", int'(fs_a), 1);
  endtask

  task automatic load(input int ch, input int v);
    target_pw[ch*PW_W +: PW_W] = PW_W'(v);
    target_valid[ch] = 1'b1;
    @(negedge clk);
    target_valid = '0;
  endtask

  task automatic frame_high(input string nm, input int reen_at, input int drop_at, input int exp);
    int h = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == drop_at) enable = 1'b0;
      if (i == reen_at) enable = 1'b1;
      h += int'(pwm_a[0]);
    end
    chk(nm, h, exp);
  endtask

  initial begin
    int c;
    // 1. reset and enable
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_a), 0);
    chk("rst_cur0", sl(cur_a, 0), 30);
    chk("rst_cur1", sl(cur_a, 1), 30);
    chk("rst_settled", int'(set_a), 3);
    chk("rst_fs", int'(fs_a), 0);
    rst_n = 1'b1; enable = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!fs_a && c < 2 * FRAME);
    chk("first_boundary", c, FRAME);
    begin
      int h0 = 0, h1 = 0;
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        h0 += int'(pwm_a[0]); h1 += int'(pwm_a[1]);
      end
      chk("center_high0", h0, 60);
      chk("center_high1", h1, 60);
    end
    // 2. slew
    repeat (50) @(negedge clk);
    load(0, 54);
    wait_fs(); chk("slew1", sl(cur_a, 0), 38); chk("slew1_set", int'(set_a[0]), 0);
    chk("direct54", sl(cur_b, 0), 54);
    wait_fs(); chk("slew2", sl(cur_a, 0), 46);
    wait_fs(); chk("slew3", sl(cur_a, 0), 54); chk("slew3_set", int'(set_a[0]), 1);
    chk("ch1_still", sl(cur_a, 1), 30);
    // 3. clamping
    repeat (30) @(negedge clk);
    load(1, 5);
    wait_fs(); chk("clamp_lo1", sl(cur_a, 1), 22);
    wait_fs(); chk("clamp_lo2", sl(cur_a, 1), 14);
    wait_fs(); chk("clamp_lo3", sl(cur_a, 1), 10);
    load(1, 2047);
    wait_fs(); chk("clamp_hi", sl(cur_b, 1), 60); chk("clamp_hi_a", sl(cur_a, 1), 18);
    // 4. coincident load
    load(0, 30);
    wait_fs(); wait_fs(); wait_fs();
    chk("back30", sl(cur_a, 0), 30);
    repeat (FRAME - 1) @(negedge clk);
    target_pw[0 +: PW_W] = PW_W'(40); target_valid = 2'b01;
    @(negedge clk); target_valid = '0;
    chk("coinc_fs", int'(fs_a), 1);
    chk("coinc_keep", sl(cur_a, 0), 30);
    chk("coinc_keep_b", sl(cur_b, 0), 30);
    wait_fs(); chk("coinc_38", sl(cur_a, 0), 38); chk("coinc_b40", sl(cur_b, 0), 40);
    wait_fs(); chk("coinc_40", sl(cur_a, 0), 40);
    // 5. enable drop, then re-assert
    frame_high("drop_full_pulse", -1, 10, 80);
    frame_high("disabled_frame", 100, -1, 0);
    frame_high("resumed_frame", -1, -1, 80);
    // 6. reset mid-pulse
    load(0, 54);
    wait_fs(); wait_fs();
    chk("pre_rst54", sl(cur_a, 0), 54);
    repeat (20) @(negedge clk);
    chk("mid_pulse_high", int'(pwm_a[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_pwm", int'(pwm_a), 0);
    chk("async_rst_pwm_b", int'(pwm_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_cur0", sl(cur_a, 0), 30);
    chk("post_rst_set", int'(set_a), 3);
    target_pw = {PW_W'(60), PW_W'(60)}; target_valid = 2'b11;
    @(negedge clk); target_valid = '0;
    wait_fs();
    chk("direct60_0", sl(cur_b, 0), 60);
    chk("direct60_1", sl(cur_b, 1), 60);
    chk("slew_after_rst", sl(cur_a, 0), 38);
    // random phase
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      target_pw = NCH*PW_W'($urandom);
      for (int k = 0; k < NCH; k++) target_valid[k] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
    end
    @(negedge clk); target_valid = '0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
